// File: rtl/midi_event_framer.sv
// MIDI channel-voice event framer: parses a strobed byte stream (running status, realtime
// pass-over) into {cmd, p1, p2} events and buffers them in a FIFO with a saturating drop count.
module midi_event_framer #(
    parameter int unsigned FIFO_DEPTH        = 4,
    parameter bit          CHANNEL_FILTER_EN = 1'b0,
    parameter logic [3:0]  CHANNEL           = 4'd0,
    parameter bit          NOTE_OFF_CONVERT  = 1'b1
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [7:0] din_i,
    input  logic       din_valid_i,
    output logic [7:0] event_cmd_o,
    output logic [7:0] event_p1_o,
    output logic [7:0] event_p2_o,
    output logic       event_valid_o,
    input  logic       event_ack_i,
    output logic [7:0] dropped_count_o
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FullCnt = (AW + 1)'(FIFO_DEPTH);

    logic [7:0]  running_cmd_q, running_cmd_d;
    logic        run_valid_q, run_valid_d;
    logic        recvd_q, recvd_d;
    logic [7:0]  p1_q, p1_d;
    logic        one_param;
    logic        ev_done, ev_keep;
    logic [7:0]  ev_cmd, ev_p1, ev_p2;

    logic [23:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0] count_q, count_d;
    logic [7:0]  dropped_q;
    logic        empty, full, push, pop, drop;

    assign one_param = (running_cmd_q[7:4] == 4'hC) || (running_cmd_q[7:4] == 4'hD);

    always_comb begin
        running_cmd_d = running_cmd_q;
        run_valid_d   = run_valid_q;
        recvd_d       = recvd_q;
        p1_d          = p1_q;
        ev_done       = 1'b0;
        ev_cmd        = running_cmd_q;
        ev_p1         = p1_q;
        ev_p2         = din_i;
        if (din_valid_i) begin
            if (din_i[7]) begin
                if (din_i < 8'hF0) begin
                    running_cmd_d = din_i;
                    run_valid_d   = 1'b1;
                    recvd_d       = 1'b0;
                end else if (din_i < 8'hF8) begin
                    run_valid_d = 1'b0;
                    recvd_d     = 1'b0;
                end
                // 0xF8-0xFF realtime bytes leave the parser untouched
            end else if (run_valid_q) begin
                if (!one_param && !recvd_q) begin
                    p1_d    = din_i;
                    recvd_d = 1'b1;
                end else begin
                    ev_done = 1'b1;
                    recvd_d = 1'b0;
                    if (one_param) begin
                        ev_p1 = din_i;
                        ev_p2 = 8'h00;
                    end
                end
            end
        end
        if (NOTE_OFF_CONVERT && ev_cmd[7:4] == 4'h9 && ev_p2 == 8'h00) begin
            ev_cmd[7:4] = 4'h8;
        end
        ev_keep = ev_done && (!CHANNEL_FILTER_EN || ev_cmd[3:0] == CHANNEL);
    end

    assign empty = (count_q == '0);
    assign full  = (count_q == FullCnt);
    assign pop   = event_ack_i && !empty;
    assign push  = ev_keep && (!full || pop);
    assign drop  = ev_keep && full && !pop;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            running_cmd_q <= 8'h00;
            run_valid_q   <= 1'b0;
            recvd_q       <= 1'b0;
            p1_q          <= 8'h00;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            dropped_q     <= 8'h00;
        end else begin
            running_cmd_q <= running_cmd_d;
            run_valid_q   <= run_valid_d;
            recvd_q       <= recvd_d;
            p1_q          <= p1_d;
            count_q       <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (drop && dropped_q != 8'hFF) begin
                dropped_q <= dropped_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {ev_cmd, ev_p1, ev_p2};
        end
    end

    assign event_valid_o = !empty;
    assign {event_cmd_o, event_p1_o, event_p2_o} = empty ? 24'h000000 : mem_q[rd_ptr_q];
    assign dropped_count_o = dropped_q;

endmodule

// File: tb/tb_midi_event_framer.sv
// Randomised + directed bench for midi_event_framer: a queue-based event model feeds per-DUT
// scoreboards; one DUT unfiltered, one filtered to channel 3.
module tb_midi_event_framer;

    localparam int Depth = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] din = 8'h00;
    logic       din_valid = 1'b0;
    logic       ack = 1'b0;

    logic [7:0] cmd0, p1_0, p2_0, dc0, cmd1, p1_1, p2_1, dc1;
    logic       v0, v1;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    midi_event_framer dut0 (
        .clk_i(clk), .reset_i(reset), .din_i(din), .din_valid_i(din_valid),
        .event_cmd_o(cmd0), .event_p1_o(p1_0), .event_p2_o(p2_0), .event_valid_o(v0),
        .event_ack_i(ack), .dropped_count_o(dc0)
    );

    midi_event_framer #(.FIFO_DEPTH(4), .CHANNEL_FILTER_EN(1'b1), .CHANNEL(4'd3),
                        .NOTE_OFF_CONVERT(1'b1)) dut1 (
        .clk_i(clk), .reset_i(reset), .din_i(din), .din_valid_i(din_valid),
        .event_cmd_o(cmd1), .event_p1_o(p1_1), .event_p2_o(p2_1), .event_valid_o(v1),
        .event_ack_i(ack), .dropped_count_o(dc1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: message-level parser, expected FIFO contents as queues
    logic [23:0] q0[$];
    logic [23:0] q1[$];
    int          drop0 = 0;
    int          drop1 = 0;
    logic [7:0]  m_cmd;
    bit          m_run;
    logic [7:0]  dq[$];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q0.delete();
            q1.delete();
            dq.delete();
            m_run = 1'b0;
            drop0 = 0;
            drop1 = 0;
        end else if (din_valid) begin
            if (din >= 8'hF8) begin
            end else if (din >= 8'hF0) begin
                m_run = 1'b0;
                dq.delete();
            end else if (din >= 8'h80) begin
                m_cmd = din;
                m_run = 1'b1;
                dq.delete();
            end else if (m_run) begin
                int n;
                logic [7:0] c, a, b;
                dq.push_back(din);
                n = (m_cmd[7:4] == 4'hC || m_cmd[7:4] == 4'hD) ? 1 : 2;
                if (dq.size() == n) begin
                    c = m_cmd;
                    a = dq[0];
                    b = (n == 2) ? dq[1] : 8'h00;
                    dq.delete();
                    if (c[7:4] == 4'h9 && b == 8'h00) c = {4'h8, c[3:0]};
                    if (q0.size() < Depth) q0.push_back({c, a, b});
                    else if (drop0 < 255) drop0++;
                    if (c[3:0] == 4'd3) begin
                        if (q1.size() < Depth) q1.push_back({c, a, b});
                        else if (drop1 < 255) drop1++;
                    end
                end
            end
        end
    end

    // Monitor: compare presented head against scoreboard, retire entries the DUT will pop
    always @(negedge clk) begin
        if (!reset) begin
            chk("valid0", 32'(v0), 32'(q0.size() != 0));
            chk("event0", {8'h0, cmd0, p1_0, p2_0}, (q0.size() != 0) ? {8'h0, q0[0]} : 32'h0);
            chk("dropped0", 32'(dc0), 32'(drop0));
            chk("valid1", 32'(v1), 32'(q1.size() != 0));
            chk("event1", {8'h0, cmd1, p1_1, p2_1}, (q1.size() != 0) ? {8'h0, q1[0]} : 32'h0);
            chk("dropped1", 32'(dc1), 32'(drop1));
            if (ack && q0.size() != 0) void'(q0.pop_front());
            if (ack && q1.size() != 0) void'(q1.pop_front());
        end
    end

    task automatic drive(input logic v, input logic [7:0] b, input logic a);
        din_valid = v;
        din = b;
        ack = a;
        @(posedge clk);
        #1;
    endtask

    task automatic bytes(input logic [7:0] seq[$]);
        foreach (seq[i]) drive(1'b1, seq[i], 1'b1);
    endtask

    task automatic idle(input int n, input logic a);
        for (int i = 0; i < n; i++) drive(1'b0, 8'h00, a);
    endtask

    initial begin
        #12;
        chk("reset_valid", 32'(v0), 32'h0);
        chk("reset_event", {8'h0, cmd0, p1_0, p2_0}, 32'h0);
        chk("reset_drop", 32'(dc0), 32'h0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Basic, one-param, running status, sysex discard, realtime interleave, conversion
        bytes('{8'h92, 8'h3C, 8'h64});
        chk("latency", 32'(v0), 32'h1);
        bytes('{8'hC5, 8'h07});
        bytes('{8'h90, 8'h40, 8'h7F, 8'h41, 8'h7F, 8'h42});
        bytes('{8'hF0, 8'h10, 8'h20});
        bytes('{8'hB1, 8'h07, 8'hF8, 8'h64, 8'hF8});
        bytes('{8'h93, 8'h3C, 8'h00});
        bytes('{8'h94, 8'h3C, 8'h40});
        idle(3, 1'b1);

        // Overflow with pops held off, then push-with-pop while full
        drive(1'b1, 8'h93, 1'b0);
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, 8'(k + 1), 1'b0);
            drive(1'b1, 8'(8'h10 + k), 1'b0);
        end
        idle(1, 1'b0);
        chk("ovf_drop0", 32'(dc0), 32'd2);
        chk("ovf_drop1", 32'(dc1), 32'd2);
        drive(1'b1, 8'h50, 1'b0);
        drive(1'b1, 8'h51, 1'b1);
        idle(1, 1'b0);
        chk("full_pushpop", 32'(dc0), 32'd2);
        idle(6, 1'b1);

        // Saturating drop counter
        for (int k = 0; k < 304; k++) begin
            drive(1'b1, 8'h22, 1'b0);
            drive(1'b1, 8'h33, 1'b0);
        end
        idle(1, 1'b0);
        chk("sat_drop", 32'(dc0), 32'd255);
        idle(6, 1'b1);

        // Randomised stream
        for (int i = 0; i < 3000; i++) begin
            int r;
            logic [7:0] b;
            r = $urandom_range(0, 9);
            if (r == 0) b = 8'(8'hF0 + $urandom_range(0, 15));
            else if (r < 3) b = 8'(8'h80 + $urandom_range(0, 8'h6F));
            else if (r == 3) b = 8'h00;
            else b = 8'($urandom_range(0, 127));
            drive($urandom_range(0, 3) != 0, b, $urandom_range(0, 2) != 0);
        end
        idle(6, 1'b1);

        // Asynchronous reset mid-message
        bytes('{8'h90, 8'h40});
        #2 reset = 1'b1;
        #1;
        chk("mid_reset_valid", 32'(v0), 32'h0);
        chk("mid_reset_event", {8'h0, cmd0, p1_0, p2_0}, 32'h0);
        chk("mid_reset_drop", 32'(dc0), 32'h0);
        #3 reset = 1'b0;
        @(posedge clk);
        #1;
        drive(1'b1, 8'h7F, 1'b1);
        idle(2, 1'b1);
        chk("post_reset_noevent", 32'(v0), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/midi_event_framer.md
# midi_event_framer

Parametrised successor to the MIDI byte framer: converts a strobed raw MIDI byte stream into complete channel-voice events, with running status support, optional channel filtering, and optional note-on-velocity-0 to note-off conversion. Completed events are buffered in an internal event FIFO with a valid/ack pop interface and a saturating drop counter. The block sits between the MIDI UART receiver and the voice allocator, and runs entirely in the system clock domain.

## Interface
- FIFO_DEPTH, 4: event FIFO depth; power of two, minimum 2.
- CHANNEL_FILTER_EN, 0: when 1, only events whose cmd[3:0] equals CHANNEL are pushed.
- CHANNEL, 0: 4-bit MIDI channel number used when CHANNEL_FILTER_EN=1.
- NOTE_OFF_CONVERT, 1: when 1, a 0x9n event with p2==0 is pushed as 0x8n, p1 unchanged, p2=0.
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- din  input  8  raw MIDI byte.
- din_valid  input  1  one-cycle strobe; din is consumed in the cycle it is high.
- event_cmd  output  8  command byte of the FIFO head event.
- event_p1  output  8  parameter 1 of the head event.
- event_p2  output  8  parameter 2 of the head event; 0 for one-parameter commands.
- event_valid  output  1  FIFO is non-empty; head event is on event_*.
- event_ack  input  1  pops the head when sampled high together with event_valid.
- dropped_count  output  8  events lost to a full FIFO; saturates at 255.

## Operation
- **Parser state:** running_cmd (8b), run_valid (1b), expected (1 or 2), recvd (0..1), p1 latch.
- **Channel status 0x80–0xEF** (with din_valid):
  - Sets running_cmd = din and run_valid = 1.
  - expected = 1 for 0xCn and 0xDn; expected = 2 otherwise.
  - Sets recvd = 0 and discards any partial message.
- **System common 0xF0–0xF7:** clears run_valid and recvd. Data bytes that follow (sysex payload) are discarded.
- **Realtime 0xF8–0xFF:** ignored entirely. Parser state is untouched, so a realtime byte may sit between the data bytes of a message.
- **Data bytes (din[7]=0):**
  - Discarded while run_valid=0.
  - Otherwise, if recvd+1 < expected, latch p1 = din and set recvd = 1.
  - Otherwise the event completes:
    - 1-param command: {running_cmd, din, 0}.
    - 2-param command: {running_cmd, p1, din}.
    - recvd returns to 0 and run_valid stays 1. This is running status: further data-byte pairs (or singles) form new events with the same command.
- **Completed event processing:**
  - NOTE_OFF_CONVERT is applied first.
  - The channel filter is applied next. A filtered event is dropped silently and does not touch dropped_count.
  - The event is then pushed to the FIFO.
- **FIFO pointers and push/pop rules:**
  - Read/write pointers are log2(FIFO_DEPTH) bits wide and wrap modulo FIFO_DEPTH. Occupancy counter is log2(FIFO_DEPTH)+1 bits.
  - Push when not full. Also push when full if a pop occurs in the same cycle (occupancy unchanged).
  - Push when full with no pop: the new event is discarded, the FIFO is unchanged, and dropped_count increments unless already 255.
  - Pop with event_valid=0 is ignored.
  - Simultaneous push and pop on an empty FIFO: the pop is ignored and the push takes effect.
- **Outputs:** event_cmd, event_p1 and event_p2 show the head entry when event_valid=1, and are forced to 0 when event_valid=0.

## Timing
- **Reset values** (asynchronous): event_valid=0, event_cmd/p1/p2=0, dropped_count=0, FIFO empty, run_valid=0, recvd=0, p1 latch=0. FIFO storage contents need not be cleared.
- **Reset mid-message:** any partial message is discarded. After reset deasserts, a status byte is required before data is accepted.
- **Latency:** event_valid rises in the cycle after the clock edge that samples the final data byte with din_valid=1, provided the FIFO was empty.
- **Pop timing:** a pop at edge N presents the next entry (or event_valid=0) after edge N.
- **Back-to-back input:** din_valid may be high every cycle. The parser sustains 1 byte/cycle, and the FIFO sustains 1 push plus 1 pop per cycle.
- **dropped_count:** updates at the same edge as the rejected push.

## Test plan
- **Basic events:** 0x92,0x3C,0x64 strobed → one event {0x92,0x3C,0x64}, event_valid high the cycle after the third byte. Then 0xC5,0x07 → {0xC5,0x07,0x00}.
- **Running status:** 0x90,0x40,0x7F,0x41,0x7F,0x42 → two events {0x90,0x40,0x7F} and {0x90,0x41,0x7F}. 0x42 is held as p1 with no third event. A following 0xF0 then 0x10,0x20 → no events.
- **Realtime interleave:** 0xB1,0x07,0xF8,0x64 → one event {0xB1,0x07,0x64}. 0xF8 alone → no state change.
- **Note-off conversion and filter:** with NOTE_OFF_CONVERT=1, 0x93,0x3C,0x00 → {0x83,0x3C,0x00}. With CHANNEL_FILTER_EN=1, CHANNEL=3, 0x94,0x3C,0x40 → no event and dropped_count stays 0.
- **Overflow:** with FIFO_DEPTH=4 and event_ack=0, push 6 events → event_valid=1, the first 4 events pop in order, dropped_count=2. Push while full with event_ack=1 in the same cycle → accepted, dropped_count unchanged. 300 drops → dropped_count=255.
- **Reset mid-operation:** send 0x90,0x40, assert reset asynchronously mid-cycle, deassert, then 0x7F → no event. FIFO empty, all outputs 0 immediately on reset assertion.
